phase_controller: RTL and testbench

PHASE_CONTROLLER -- requirements
Module: phase_controller

---
 rtl/simple_ctrl_pkg.sv | 37 +++
 rtl/phase_controller_cond_latch.sv | 19 +
 rtl/phase_controller.sv | 96 +++++++++
 tb/tb_phase_controller.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/simple_ctrl_pkg.sv
// Shared types and constants for the five-phase instruction controller.
package simple_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_P1,
      ST_P2,
      ST_P3,
      ST_P4,
      ST_P5,
      ST_HALTED
   } phase_state_t;

   localparam logic [4:0] PH_P1 = 5'b00001;
   localparam logic [4:0] PH_P2 = 5'b00010;
   localparam logic [4:0] PH_P3 = 5'b00100;
   localparam logic [4:0] PH_P4 = 5'b01000;
   localparam logic [4:0] PH_P5 = 5'b10000;

   localparam int COND_S = 3;
   localparam int COND_Z = 2;
   localparam int COND_C = 1;
   localparam int COND_V = 0;

   // IDLE and HALTED have no phase bit set.
   function automatic logic [4:0] phase_code(input phase_state_t s);
      case (s)
         ST_P1:   phase_code = PH_P1;
         ST_P2:   phase_code = PH_P2;
         ST_P3:   phase_code = PH_P3;
         ST_P4:   phase_code = PH_P4;
         ST_P5:   phase_code = PH_P5;
         default: phase_code = 5'b00000;
      endcase
   endfunction

endpackage

// File: rtl/phase_controller_cond_latch.sv
// Flag register {S,Z,C,V}, loaded when its write enable is asserted.
module cond_latch
   import simple_ctrl_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] cond_in,
   output logic [3:0] cond
);

   always_ff @(posedge clock) begin
      if (!reset)
         cond <= 4'b0000;
      else if (load)
         cond <= cond_in;
   end

endmodule

// File: rtl/phase_controller.sv
// Five-phase instruction sequencer with fetch/memory handshakes and halt/stop control.
// Optional feature: define SINGLE_STEP_EN to let 'step' run exactly one instruction.
module phase_controller
   import simple_ctrl_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        run,
   input  logic        stop,
   input  logic        step,
   input  logic        halt_req,
   input  logic        mem_access,
   input  logic        mem_ack,
   input  logic [3:0]  cond_in,
   input  logic        cond_we,
   output logic [4:0]  phasecounter,
   output logic        mem_req,
   output logic [3:0]  cond,
   output logic        running,
   output logic [15:0] instr_count
);

   phase_state_t state_q, state_d;
   logic         stop_pending;
   logic         step_start;

`ifndef SINGLE_STEP_EN
   logic unused_step;
   assign unused_step = step;
`endif

   always_comb begin
      state_d    = state_q;
      step_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
`ifdef SINGLE_STEP_EN
            if (step) begin
               state_d    = ST_P1;
               step_start = 1'b1;
            end else
`endif
            if (run && !stop)
               state_d = ST_P1;
         end
         ST_P1: if (mem_ack) state_d = ST_P2;
         ST_P2: state_d = halt_req ? ST_HALTED : ST_P3;
         ST_P3: state_d = ST_P4;
         ST_P4: if (!mem_access || mem_ack) state_d = ST_P5;
         // A stop arriving in P5 itself is still honoured at this boundary.
         ST_P5: state_d = (stop_pending || stop) ? ST_IDLE : ST_P1;
         ST_HALTED: begin
            if (stop)
               state_d = ST_IDLE;
`ifdef SINGLE_STEP_EN
            else if (step) begin
               state_d    = ST_P1;
               step_start = 1'b1;
            end
`endif
            else if (run)
               state_d = ST_P1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign phasecounter = phase_code(state_q);
   assign running      = (phasecounter != 5'b00000);
   assign mem_req      = (state_q == ST_P1) || ((state_q == ST_P4) && mem_access);

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         stop_pending <= 1'b0;
         instr_count  <= 16'h0000;
      end else begin
         state_q <= state_d;
         if ((state_d == ST_IDLE) || (state_d == ST_HALTED))
            stop_pending <= 1'b0;
         else if (step_start || (running && stop))
            stop_pending <= 1'b1;
         if (state_q == ST_P5)
            instr_count <= instr_count + 16'd1;
      end
   end

   cond_latch u_cond_latch (
      .clock   (clock),
      .reset   (reset),
      .load    ((state_q == ST_P3) && cond_we),
      .cond_in (cond_in),
      .cond    (cond)
   );

endmodule

// File: tb/tb_phase_controller.sv
// Scoreboard bench for phase_controller: directed rows push expected outputs, a monitor compares.
module tb_phase_controller;

   logic        clock = 1'b0;
   logic        reset;
   logic        run, stop, step, halt_req, mem_access, mem_ack, cond_we;
   logic [3:0]  cond_in;
   logic [4:0]  phasecounter;
   logic        mem_req, running;
   logic [3:0]  cond;
   logic [15:0] instr_count;

   typedef struct packed {
      logic [4:0]  ph;
      logic        req;
      logic [3:0]  cnd;
      logic [15:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   row    = 0;

   always #5 clock = ~clock;

   phase_controller dut (
      .clock        (clock),
      .reset        (reset),
      .run          (run),
      .stop         (stop),
      .step         (step),
      .halt_req     (halt_req),
      .mem_access   (mem_access),
      .mem_ack      (mem_ack),
      .cond_in      (cond_in),
      .cond_we      (cond_we),
      .phasecounter (phasecounter),
      .mem_req      (mem_req),
      .cond         (cond),
      .running      (running),
      .instr_count  (instr_count)
   );

   // Each row drives one cycle's inputs and queues the outputs expected during that cycle.
   task automatic applyStimulus(input logic rst_v, input logic run_v, input logic stop_v,
                                input logic step_v, input logic halt_v, input logic macc_v,
                                input logic ack_v, input logic we_v, input logic [3:0] cin_v,
                                input logic [4:0] e_ph, input logic e_req,
                                input logic [3:0] e_cnd, input logic [15:0] e_cnt);
      exp_t e;
      @(posedge clock);
      #1;
      reset      = rst_v;
      run        = run_v;
      stop       = stop_v;
      step       = step_v;
      halt_req   = halt_v;
      mem_access = macc_v;
      mem_ack    = ack_v;
      cond_we    = we_v;
      cond_in    = cin_v;
      e.ph  = e_ph;
      e.req = e_req;
      e.cnd = e_cnd;
      e.cnt = e_cnt;
      exp_q.push_back(e);
   endtask

   task automatic checkOutput(input exp_t e);
      logic e_run;
      e_run = (e.ph != 5'b00000);
      checks++;
      if (phasecounter !== e.ph || mem_req !== e.req || running !== e_run ||
          cond !== e.cnd || instr_count !== e.cnt) begin
         errors++;
         $display("[TB] FAIL row%0d: got ph=%b req=%b run=%b cond=%b cnt=%0d, expected ph=%b req=%b run=%b cond=%b cnt=%0d",
                  row, phasecounter, mem_req, running, cond, instr_count,
                  e.ph, e.req, e_run, e.cnd, e.cnt);
      end
      row++;
   endtask

   always @(negedge clock) begin
      if (exp_q.size() > 0)
         checkOutput(exp_q.pop_front());
   end

   initial begin
      reset = 1'b0; run = 1'b0; stop = 1'b0; step = 1'b0; halt_req = 1'b0;
      mem_access = 1'b0; mem_ack = 1'b0; cond_we = 1'b0; cond_in = 4'b0000;
      repeat (2) @(posedge clock);

      //            rst run stp stepp hlt mac ack we  cin      ph        req cond     cnt
      // Reset state, then back-to-back zero-wait instructions
      applyStimulus(1, 1, 0, 0, 0, 0, 1, 0, 4'b0000, 5'b00000, 0, 4'b0000, 16'd0);
      applyStimulus(1, 1, 0, 0, 0, 0, 1, 0, 4'b0000, 5'b00001, 1, 4'b0000, 16'd0);
      applyStimulus(1, 1, 0, 0, 0, 0, 1, 0, 4'b0000, 5'b00010, 0, 4'b0000, 16'd0);
      applyStimulus(1, 1, 0, 0, 0, 0, 1, 0, 4'b0000, 5'b00100, 0, 4'b0000, 16'd0);
      applyStimulus(1, 1, 0, 0, 0, 0, 1, 0, 4'b0000, 5'b01000, 0, 4'b0000, 16'd0);
      applyStimulus(1, 1, 0, 0, 0, 0, 1, 0, 4'b0000, 5'b10000, 0, 4'b0000, 16'd0);
      // Fetch waits three cycles, flags written, P4 load waits two cycles
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 5'b00001, 1, 4'b0000, 16'd1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 5'b00001, 1, 4'b0000, 16'd1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 5'b00001, 1, 4'b0000, 16'd1);
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 5'b00001, 1, 4'b0000, 16'd1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 5'b00010, 0, 4'b0000, 16'd1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 4'b1010, 5'b00100, 0, 4'b0000, 16'd1);
      applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 4'b0000, 5'b01000, 1, 4'b1010, 16'd1);
      applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 4'b0000, 5'b01000, 1, 4'b1010, 16'd1);
      applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 4'b0000, 5'b01000, 1, 4'b1010, 16'd1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 5'b10000, 0, 4'b1010, 16'd1);
      // Stop pulse in P2; cond_we=0 must not disturb the flags
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 5'b00001, 1, 4'b1010, 16'd2);
      applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 4'b0000, 5'b00010, 0, 4'b1010, 16'd2);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 4'b0101, 5'b00100, 0, 4'b1010, 16'd2);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 5'b01000, 0, 4'b1010, 16'd2);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 5'b10000, 0, 4'b1010, 16'd2);
      // run with stop in IDLE holds IDLE
      applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 4'b0000, 5'b00000, 0, 4'b1010, 16'd3);
      applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 4'b0000, 5'b00000, 0, 4'b1010, 16'd3);
      applyStimulus(1, 1, 0, 0, 0, 0, 1, 0, 4'b0000, 5'b00000, 0, 4'b1010, 16'd3);
      // HLT in P2, resume with run
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 5'b00001, 1, 4'b1010, 16'd3);
      applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 5'b00010, 0, 4'b1010, 16'd3);
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 5'b00000, 0, 4'b1010, 16'd3);
      applyStimulus(1, 1, 0, 0, 0, 0, 1, 0, 4'b0000, 5'b00000, 0, 4'b1010, 16'd3);
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 5'b00001, 1, 4'b1010, 16'd3);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 5'b00010, 0, 4'b1010, 16'd3);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 5'b00100, 0, 4'b1010, 16'd3);
      // Reset asserted in the middle of a P4 memory wait
      applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 4'b0000, 5'b01000, 1, 4'b1010, 16'd3);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 4'b0000, 5'b01000, 1, 4'b1010, 16'd3);
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 5'b00000, 0, 4'b0000, 16'd0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 5'b00000, 0, 4'b0000, 16'd0);
`ifdef SINGLE_STEP_EN
      // One step runs a single instruction and returns to IDLE
      applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 4'b0000, 5'b00000, 0, 4'b0000, 16'd0);
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 5'b00001, 1, 4'b0000, 16'd0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 5'b00010, 0, 4'b0000, 16'd0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 5'b00100, 0, 4'b0000, 16'd0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 5'b01000, 0, 4'b0000, 16'd0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 5'b10000, 0, 4'b0000, 16'd0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 5'b00000, 0, 4'b0000, 16'd1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 5'b00000, 0, 4'b0000, 16'd1);
`else
      // step is ignored in the default build
      applyStimulus(1, 0, 0, 1, 0, 0, 1, 0, 4'b0000, 5'b00000, 0, 4'b0000, 16'd0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 5'b00000, 0, 4'b0000, 16'd0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 5'b00000, 0, 4'b0000, 16'd0);
`endif

      @(posedge clock);
      @(negedge clock);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d entries left in scoreboard, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
